// File: rtl/uart_hd_pkg.sv
// Shared types and timing helpers for the half-duplex UART line controller.
package uart_hd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_BUSY,
    TURN_TX,
    TX_START,
    TX_WAIT,
    GUARD_RX
  } hd_state_e;

  localparam int CLKS_PER_BIT_DEF = 87;
  localparam int GUARD_BITS_DEF   = 2;
  localparam int TIMEOUT_BITS_DEF = 12;

  localparam int GUARD_CLKS   = GUARD_BITS_DEF * CLKS_PER_BIT_DEF;
  localparam int TIMEOUT_CLKS = TIMEOUT_BITS_DEF * CLKS_PER_BIT_DEF;

  function automatic int cnt_width(input int clks_per_bit, input int timeout_bits);
    return $clog2(clks_per_bit * timeout_bits + 1);
  endfunction

endpackage

// File: rtl/uart_hd_bit_timer.sv
// Down-counter shared by all timed states: load on state entry, count to 0, hold there.
module uart_hd_bit_timer #(
  parameter int W = 11
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/uart_hd_line_ctrl.sv
// Half-duplex line sequencer between host byte handshakes and the Uart_Tx / Uart_RX cores.
// Owns driver direction, guard time, RX priority, self-echo gating and frame timeouts.
module uart_hd_line_ctrl
  import uart_hd_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int GUARD_BITS   = GUARD_BITS_DEF,
  parameter int TIMEOUT_BITS = TIMEOUT_BITS_DEF
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Line_Serial,
  input  logic       i_Host_Tx_Valid,
  input  logic [7:0] i_Host_Tx_Byte,
  output logic       o_Host_Tx_Ready,
  output logic       o_Host_Rx_Valid,
  output logic [7:0] o_Host_Rx_Byte,
  input  logic       i_Host_Rx_Ready,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  input  logic       i_Tx_Done,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Dir_Tx,
  output logic       o_Overrun,
  output logic       o_Timeout
);

  localparam int CW        = cnt_width(CLKS_PER_BIT, TIMEOUT_BITS);
  localparam int GUARD_N   = GUARD_BITS * CLKS_PER_BIT;
  localparam int TIMEOUT_N = TIMEOUT_BITS * CLKS_PER_BIT;
  // Each timed state lasts exactly N cycles: the exit is taken on the edge after the count hits 0.
  localparam logic [CW-1:0] GUARD_LOAD   = CW'(GUARD_N - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_N - 1);

  hd_state_e     state_q, state_d;
  logic [1:0]    sync_q;
  logic          run_q;
  logic          dir_tx_q, tx_dv_q, rx_valid_q, overrun_q, timeout_q;
  logic [7:0]    tx_byte_q, rx_byte_q;
  logic          start, tx_ready, tx_accept, rx_deliver, rx_blocked;
  logic          tmr_load, tmr_expired;
  logic [CW-1:0] tmr_load_val;

  assign start      = ~sync_q[1];
  // run_q keeps Ready low while reset is held and for the first cycle after release.
  assign tx_ready   = run_q && (state_q == IDLE) && !start;
  assign tx_accept  = tx_ready && i_Host_Tx_Valid;
  assign rx_deliver = (state_q == RX_BUSY) && i_Rx_DV;
  assign rx_blocked = rx_valid_q && !i_Host_Rx_Ready;

  uart_hd_bit_timer #(.W(CW)) u_timer (
    .clk_i      (i_Clock),
    .rst_ni     (i_Reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .en_i       (state_q != IDLE),
    .expired_o  (tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = GUARD_LOAD;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RX_BUSY;
          tmr_load     = 1'b1;
          tmr_load_val = TIMEOUT_LOAD;
        end else if (tx_accept) begin
          state_d  = TURN_TX;
          tmr_load = 1'b1;
        end
      end
      RX_BUSY: begin
        if (i_Rx_DV || tmr_expired) begin
          state_d  = GUARD_RX;
          tmr_load = 1'b1;
        end
      end
      TURN_TX:  if (tmr_expired) state_d = TX_START;
      TX_START: begin
        state_d      = TX_WAIT;
        tmr_load     = 1'b1;
        tmr_load_val = TIMEOUT_LOAD;
      end
      TX_WAIT: begin
        if (i_Tx_Done || tmr_expired) begin
          state_d  = GUARD_RX;
          tmr_load = 1'b1;
        end
      end
      GUARD_RX: if (tmr_expired) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q    <= IDLE;
      sync_q     <= 2'b11;
      run_q      <= 1'b0;
      dir_tx_q   <= 1'b0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= 8'h00;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], i_Line_Serial};
      run_q     <= 1'b1;
      state_q   <= state_d;
      dir_tx_q  <= (state_d inside {TURN_TX, TX_START, TX_WAIT});
      tx_dv_q   <= (state_d == TX_START);
      timeout_q <= tmr_expired && (((state_q == RX_BUSY) && !i_Rx_DV) ||
                                   ((state_q == TX_WAIT) && !i_Tx_Done));
      overrun_q <= rx_deliver && rx_blocked;
      if (tx_accept) begin
        tx_byte_q <= i_Host_Tx_Byte;
      end
      // A byte arriving while the previous one is still unread is dropped; the old one stays.
      if (rx_deliver && !rx_blocked) begin
        rx_valid_q <= 1'b1;
        rx_byte_q  <= i_Rx_Byte;
      end else if (rx_valid_q && i_Host_Rx_Ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign o_Host_Tx_Ready = tx_ready;
  assign o_Host_Rx_Valid = rx_valid_q;
  assign o_Host_Rx_Byte  = rx_byte_q;
  assign o_Tx_DV         = tx_dv_q;
  assign o_Tx_Byte       = tx_byte_q;
  assign o_Dir_Tx        = dir_tx_q;
  assign o_Overrun       = overrun_q;
  assign o_Timeout       = timeout_q;

endmodule

// File: tb/tb_uart_hd_line_ctrl.sv
// Directed bench for uart_hd_line_ctrl with behavioural TX serializer and remote sender on a shared line.
module tb_uart_hd_line_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       remote_ser = 1'b1;
  logic       tx_ser = 1'b1;
  logic       line;
  logic       host_tx_valid = 1'b0;
  logic [7:0] host_tx_byte = 8'h00;
  logic       host_tx_ready;
  logic       host_rx_valid;
  logic [7:0] host_rx_byte;
  logic       host_rx_ready = 1'b0;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_done = 1'b0;
  logic       rx_dv_remote = 1'b0;
  logic       rx_dv_echo = 1'b0;
  logic [7:0] rx_byte_remote = 8'h00;
  logic [7:0] rx_byte_echo = 8'h00;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       dir_tx, overrun, timeout;
  logic [7:0] line_cap = 8'h00;
  int         errors = 0;
  int         checks = 0;
  int         ovr_cnt = 0;
  int         to_cnt = 0;

  always #5 clk = ~clk;

  assign line    = dir_tx ? tx_ser : remote_ser;
  assign rx_dv   = rx_dv_remote | rx_dv_echo;
  assign rx_byte = rx_dv_echo ? rx_byte_echo : rx_byte_remote;

  uart_hd_line_ctrl dut (
    .i_Clock         (clk),
    .i_Reset_n       (rst_n),
    .i_Line_Serial   (line),
    .i_Host_Tx_Valid (host_tx_valid),
    .i_Host_Tx_Byte  (host_tx_byte),
    .o_Host_Tx_Ready (host_tx_ready),
    .o_Host_Rx_Valid (host_rx_valid),
    .o_Host_Rx_Byte  (host_rx_byte),
    .i_Host_Rx_Ready (host_rx_ready),
    .o_Tx_DV         (tx_dv),
    .o_Tx_Byte       (tx_byte),
    .i_Tx_Done       (tx_done),
    .i_Rx_DV         (rx_dv),
    .i_Rx_Byte       (rx_byte),
    .o_Dir_Tx        (dir_tx),
    .o_Overrun       (overrun),
    .o_Timeout       (timeout)
  );

  always begin
    @(posedge clk);
    #2;
    if (overrun === 1'b1) ovr_cnt++;
    if (timeout === 1'b1) to_cnt++;
  end

  // Uart_Tx stand-in: serialises o_Tx_Byte, samples the shared line mid-bit, then echoes it as Uart_RX would.
  always begin
    @(posedge clk);
    #2;
    if (rst_n === 1'b1 && tx_dv === 1'b1) begin
      for (int k = 0; k < 870 && rst_n === 1'b1; k++) begin
        int bi;
        bi = k / 87;
        if ((k % 87) == 43 && bi >= 1 && bi <= 8) line_cap[bi-1] = line;
        if (bi == 0)      tx_ser = 1'b0;
        else if (bi == 9) tx_ser = 1'b1;
        else              tx_ser = tx_byte[bi-1];
        @(posedge clk);
        #2;
      end
      tx_ser = 1'b1;
      if (rst_n === 1'b1) begin
        tx_done      = 1'b1;
        rx_dv_echo   = 1'b1;
        rx_byte_echo = line_cap;
        @(posedge clk);
        #2;
        tx_done    = 1'b0;
        rx_dv_echo = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog");
  end

  // Remote frame: i_Rx_DV pulses at mid stop bit (cycle 826 of 870), optionally with host Ready in that cycle.
  task automatic remote_send(input logic [7:0] b, input logic rdy_at_dv, output int dir_hi);
    dir_hi = 0;
    for (int k = 0; k < 870; k++) begin
      int bi;
      bi = k / 87;
      if (bi == 0)      remote_ser = 1'b0;
      else if (bi == 9) remote_ser = 1'b1;
      else              remote_ser = b[bi-1];
      rx_dv_remote   = (k == 826);
      rx_byte_remote = b;
      if (rdy_at_dv) host_rx_ready = (k == 826);
      @(negedge clk);
      if (dir_tx !== 1'b0) dir_hi++;
    end
    rx_dv_remote  = 1'b0;
    remote_ser    = 1'b1;
    host_rx_ready = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int limit);
    int k;
    k = 0;
    while (host_tx_ready !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (host_tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_wait: got ready=%b after %0d cycles, required 1", tag, host_tx_ready, k);
    end
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (tx_done !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (tx_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_wait: got no i_Tx_Done in %0d cycles, required a pulse", tag, k);
    end
  endtask

  task automatic consume(input string tag);
    host_rx_ready = 1'b1;
    @(negedge clk);
    host_rx_ready = 1'b0;
    checks++;
    if (host_rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_consume: got rx_valid=%b, required 0", tag, host_rx_valid);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({dir_tx, tx_dv, host_tx_ready, host_rx_valid, overrun, timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 000000", {dir_tx, tx_dv, host_tx_ready, host_rx_valid, overrun, timeout});
    end
    checks++;
    if (tx_byte !== 8'h00 || host_rx_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_bytes: got tx=%02h rx=%02h, required 00 00", tx_byte, host_rx_byte);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (host_tx_ready !== 1'b1 || dir_tx !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b dir=%b, required 1 0", host_tx_ready, dir_tx);
    end
    $display("test_reset: ready=%b dir=%b", host_tx_ready, dir_tx);
  endtask

  task automatic test_host_tx();
    int n;
    wait_ready("host_tx", 50);
    host_tx_byte  = 8'h3F;
    host_tx_valid = 1'b1;
    @(negedge clk);
    host_tx_valid = 1'b0;
    checks++;
    if (dir_tx !== 1'b1 || host_tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL host_tx_dir_rise: got dir=%b ready=%b, required 1 0", dir_tx, host_tx_ready);
    end
    n = 1;
    while (tx_dv !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 175) begin
      errors++;
      $display("FAIL host_tx_dv_latency: got %0d cycles, required 175", n);
    end
    checks++;
    if (tx_byte !== 8'h3F) begin
      errors++;
      $display("FAIL host_tx_byte: got %02h, required 3f", tx_byte);
    end
    @(negedge clk);
    checks++;
    if (tx_dv !== 1'b0) begin
      errors++;
      $display("FAIL host_tx_dv_width: got %b, required 0", tx_dv);
    end
    wait_done("host_tx");
    checks++;
    if (dir_tx !== 1'b1) begin
      errors++;
      $display("FAIL host_tx_dir_at_done: got %b, required 1", dir_tx);
    end
    @(negedge clk);
    checks++;
    if (dir_tx !== 1'b0) begin
      errors++;
      $display("FAIL host_tx_dir_fall: got %b, required 0", dir_tx);
    end
    checks++;
    if (line_cap !== 8'h3F) begin
      errors++;
      $display("FAIL host_tx_line: got %02h, required 3f", line_cap);
    end
    repeat (173) @(negedge clk);
    checks++;
    if (host_tx_ready !== 1'b0 || host_rx_valid !== 1'b0 || ovr_cnt !== 0) begin
      errors++;
      $display("FAIL host_tx_guard_end: got ready=%b rx_valid=%b overruns=%0d, required 0 0 0",
               host_tx_ready, host_rx_valid, ovr_cnt);
    end
    @(negedge clk);
    checks++;
    if (host_tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL host_tx_ready_back: got %b, required 1", host_tx_ready);
    end
    $display("test_host_tx: byte=%02h dv_latency=%0d line=%02h", tx_byte, n, line_cap);
  endtask

  task automatic test_remote_rx();
    int dh;
    wait_ready("remote_rx", 50);
    remote_send(8'hA5, 1'b0, dh);
    checks++;
    if (dh !== 0) begin
      errors++;
      $display("FAIL remote_rx_dir: got dir high for %0d cycles, required 0", dh);
    end
    checks++;
    if (host_rx_valid !== 1'b1 || host_rx_byte !== 8'hA5) begin
      errors++;
      $display("FAIL remote_rx_byte: got valid=%b byte=%02h, required 1 a5", host_rx_valid, host_rx_byte);
    end
    repeat (130) @(negedge clk);
    checks++;
    if (host_tx_ready !== 1'b0 || dir_tx !== 1'b0) begin
      errors++;
      $display("FAIL remote_rx_guard_174: got ready=%b dir=%b, required 0 0", host_tx_ready, dir_tx);
    end
    @(negedge clk);
    checks++;
    if (host_tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL remote_rx_ready_175: got %b, required 1", host_tx_ready);
    end
    consume("remote_rx");
    $display("test_remote_rx: byte=a5 delivered, ready after guard=%b", host_tx_ready);
  endtask

  task automatic test_rx_priority();
    int dh;
    int n;
    wait_ready("rx_priority", 50);
    n = 0;
    fork
      remote_send(8'h55, 1'b0, dh);
      begin
        // Valid arrives in the cycle the synchronised start bit reaches the controller.
        repeat (2) @(negedge clk);
        host_tx_byte  = 8'h77;
        host_tx_valid = 1'b1;
        checks++;
        if (host_tx_ready !== 1'b0) begin
          errors++;
          $display("FAIL rx_priority_ready_at_start: got %b, required 0", host_tx_ready);
        end
        n = 2;
        while (host_tx_ready !== 1'b1 && n < 1500) begin
          @(negedge clk);
          n++;
        end
        @(negedge clk);
        host_tx_valid = 1'b0;
      end
    join
    checks++;
    if (n !== 1001) begin
      errors++;
      $display("FAIL rx_priority_accept_cycle: got %0d, required 1001", n);
    end
    checks++;
    if (dh !== 0 || host_rx_valid !== 1'b1 || host_rx_byte !== 8'h55) begin
      errors++;
      $display("FAIL rx_priority_rx: got dir_cycles=%0d valid=%b byte=%02h, required 0 1 55",
               dh, host_rx_valid, host_rx_byte);
    end
    consume("rx_priority");
    wait_done("rx_priority");
    @(negedge clk);
    checks++;
    if (line_cap !== 8'h77) begin
      errors++;
      $display("FAIL rx_priority_tx_line: got %02h, required 77", line_cap);
    end
    $display("test_rx_priority: rx=55 then tx line=%02h accepted at cycle %0d", line_cap, n);
  endtask

  task automatic test_overrun();
    int dh;
    int o0;
    wait_ready("overrun", 400);
    o0 = ovr_cnt;
    remote_send(8'h11, 1'b0, dh);
    checks++;
    if (host_rx_valid !== 1'b1 || host_rx_byte !== 8'h11) begin
      errors++;
      $display("FAIL overrun_first: got valid=%b byte=%02h, required 1 11", host_rx_valid, host_rx_byte);
    end
    wait_ready("overrun_gap", 400);
    remote_send(8'h22, 1'b0, dh);
    repeat (2) @(negedge clk);
    checks++;
    if (ovr_cnt - o0 !== 1) begin
      errors++;
      $display("FAIL overrun_pulses: got %0d, required 1", ovr_cnt - o0);
    end
    checks++;
    if (host_rx_valid !== 1'b1 || host_rx_byte !== 8'h11) begin
      errors++;
      $display("FAIL overrun_kept: got valid=%b byte=%02h, required 1 11", host_rx_valid, host_rx_byte);
    end
    $display("test_overrun: pulses=%0d kept=%02h", ovr_cnt - o0, host_rx_byte);
  endtask

  task automatic test_rx_ready_same_cycle();
    int dh;
    int o0;
    wait_ready("same_cycle", 400);
    o0 = ovr_cnt;
    remote_send(8'h33, 1'b1, dh);
    repeat (2) @(negedge clk);
    checks++;
    if (ovr_cnt - o0 !== 0) begin
      errors++;
      $display("FAIL same_cycle_overrun: got %0d pulses, required 0", ovr_cnt - o0);
    end
    checks++;
    if (host_rx_valid !== 1'b1 || host_rx_byte !== 8'h33) begin
      errors++;
      $display("FAIL same_cycle_byte: got valid=%b byte=%02h, required 1 33", host_rx_valid, host_rx_byte);
    end
    consume("same_cycle");
    $display("test_rx_ready_same_cycle: byte=33 accepted, overruns=%0d", ovr_cnt - o0);
  endtask

  task automatic test_timeout();
    int n;
    int t0;
    wait_ready("timeout", 400);
    t0 = to_cnt;
    remote_ser = 1'b0;
    n = 0;
    while (timeout !== 1'b1 && n < 1300) begin
      @(negedge clk);
      n++;
    end
    remote_ser = 1'b1;
    // Two synchroniser stages put RX_BUSY entry 3 cycles after the line falls.
    checks++;
    if (n !== 1047) begin
      errors++;
      $display("FAIL timeout_cycle: got %0d after line low, required 1047 (1044 after RX_BUSY entry)", n);
    end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0 || host_rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_width: got timeout=%b rx_valid=%b, required 0 0", timeout, host_rx_valid);
    end
    repeat (172) @(negedge clk);
    checks++;
    if (host_tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_guard: got ready=%b, required 0", host_tx_ready);
    end
    @(negedge clk);
    checks++;
    if (host_tx_ready !== 1'b1 || to_cnt - t0 !== 1) begin
      errors++;
      $display("FAIL timeout_idle: got ready=%b pulses=%0d, required 1 1", host_tx_ready, to_cnt - t0);
    end
    $display("test_timeout: pulse at %0d, pulses=%0d", n, to_cnt - t0);
  endtask

  task automatic test_reset_mid_tx();
    int n;
    wait_ready("reset_mid", 50);
    host_tx_byte  = 8'hC3;
    host_tx_valid = 1'b1;
    @(negedge clk);
    host_tx_valid = 1'b0;
    n = 1;
    while (tx_dv !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (100) @(negedge clk);
    checks++;
    if (dir_tx !== 1'b1 || tx_byte !== 8'hC3) begin
      errors++;
      $display("FAIL reset_mid_pre: got dir=%b byte=%02h, required 1 c3", dir_tx, tx_byte);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dir_tx, tx_dv, host_tx_ready, host_rx_valid, overrun, timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_async: got %b, required 000000", {dir_tx, tx_dv, host_tx_ready, host_rx_valid, overrun, timeout});
    end
    checks++;
    if (tx_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_byte: got %02h, required 00", tx_byte);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (host_tx_ready !== 1'b1 || dir_tx !== 1'b0 || line !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_release: got ready=%b dir=%b line=%b, required 1 0 1", host_tx_ready, dir_tx, line);
    end
    $display("test_reset_mid_tx: ready=%b dir=%b tx_byte=%02h", host_tx_ready, dir_tx, tx_byte);
  endtask

  initial begin
    test_reset();
    test_host_tx();
    test_remote_rx();
    test_rx_priority();
    test_overrun();
    test_rx_ready_same_cycle();
    test_timeout();
    test_reset_mid_tx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
